// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, one bit per clock, LSB first.
// Borrow is carried between bits in a single flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic [WIDTH-1:0] w_d_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             w_d;
  logic             w_br;
  logic             w_last;
  logic             w_accept;

  assign w_d  = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br = (~r_a_sh[0] & r_b_sh[0])
              | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = start && (r_state != S_SHIFT);

  // Current bit enters at the MSB so the word is aligned after WIDTH shifts
  always_comb begin
    w_d_sh = r_d_sh >> 1;
    w_d_sh[WIDTH-1] = w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_d_sh <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= A;
      r_b_sh <= B;
      r_br   <= Bin;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_d_sh <= w_d_sh;
      r_br   <= w_br;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        diff <= w_d_sh;
        bout <= w_br;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 1 and 16.
// Expected results are queued on issue and popped on done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s8 = 0, bi8 = 0, busy8, done8, bo8;
  logic [7:0]  a8 = 0, b8 = 0, d8;
  logic        s1 = 0, bi1 = 0, busy1, done1, bo1;
  logic [0:0]  a1 = 0, b1 = 0, d1;
  logic        s16 = 0, bi16 = 0, busy16, done16, bo16;
  logic [15:0] a16 = 0, b16 = 0, d16;

  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [16:0] q16[$];
  logic [8:0]  last8 = 0;
  logic [1:0]  last1 = 0;
  logic [16:0] last16 = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .Bin(bi8),
    .busy(busy8), .done(done8), .diff(d8), .bout(bo8));
  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(s1), .A(a1), .B(b1), .Bin(bi1),
    .busy(busy1), .done(done1), .diff(d1), .bout(bo1));
  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .A(a16), .B(b16), .Bin(bi16),
    .busy(busy16), .done(done16), .diff(d16), .bout(bo16));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard and hold/exclusivity monitors
  always @(negedge clk) if (!rst) begin
    if (busy8)  chk("hold8", 32'({bo8, d8}), 32'(last8));
    if (busy1)  chk("hold1", 32'({bo1, d1}), 32'(last1));
    if (busy16) chk("hold16", 32'({bo16, d16}), 32'(last16));
    if (busy8 && done8) chk("excl8", 32'(1), 32'(0));
    if (done8) begin
      last8 = {bo8, d8};
      if (q8.size() == 0) chk("spur8", 32'(1), 32'(0));
      else chk("res8", 32'({bo8, d8}), 32'(q8.pop_front()));
    end
    if (done1) begin
      last1 = {bo1, d1};
      if (q1.size() == 0) chk("spur1", 32'(1), 32'(0));
      else chk("res1", 32'({bo1, d1}), 32'(q1.pop_front()));
    end
    if (done16) begin
      last16 = {bo16, d16};
      if (q16.size() == 0) chk("spur16", 32'(1), 32'(0));
      else chk("res16", 32'({bo16, d16}), 32'(q16.pop_front()));
    end
  end

  always @(posedge rst) begin
    last8 = 0;
    last1 = 0;
    last16 = 0;
  end

  function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bi);
    logic [1:0]  t1;
    logic [8:0]  t8;
    logic [16:0] t16;
    t1  = {1'b0, a[0]} - {1'b0, b[0]} - {1'b0, bi};
    t8  = {1'b0, a[7:0]} - {1'b0, b[7:0]} - {8'b0, bi};
    t16 = {1'b0, a} - {1'b0, b} - {16'b0, bi};
    case (w)
      1:       return {15'b0, t1};
      8:       return {8'b0, t8};
      default: return t16;
    endcase
  endfunction

  task automatic go(input int w, input logic [15:0] a, input logic [15:0] b,
                    input logic bi, input logic [16:0] exp);
    @(negedge clk);
    case (w)
      1: begin
        s1 = 1; a1 = a[0]; b1 = b[0]; bi1 = bi; q1.push_back(exp[1:0]);
      end
      8: begin
        s8 = 1; a8 = a[7:0]; b8 = b[7:0]; bi8 = bi; q8.push_back(exp[8:0]);
      end
      default: begin
        s16 = 1; a16 = a; b16 = b; bi16 = bi; q16.push_back(exp);
      end
    endcase
    @(negedge clk);
    s1 = 0; s8 = 0; s16 = 0;
    a1 = 0; a8 = 0; a16 = 16'hFFFF; b8 = 8'hFF; b16 = 0; bi8 = ~bi;
  endtask

  task automatic wait_done(input int w, output int nb);
    logic seen;
    logic bz, dn;
    seen = 0;
    nb = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      case (w)
        1:       begin bz = busy1;  dn = done1;  end
        8:       begin bz = busy8;  dn = done8;  end
        default: begin bz = busy16; dn = done16; end
      endcase
      if (dn) seen = 1;
      else begin
        if (bz) nb++;
        @(negedge clk);
      end
    end
    chk("seen_done", 32'(seen), 32'(1));
  endtask

  int nb;
  int ndone;
  int tprev;
  logic [15:0] ra, rb;
  logic rbi;

  initial begin
    #2;
    chk("rst8", 32'({busy8, done8, bo8, d8}), 32'(0));
    chk("rst16", 32'({busy16, done16, bo16, d16}), 32'(0));
    chk("rst1", 32'({busy1, done1, bo1, d1}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 0;

    go(8, 16'h5A, 16'h3C, 0, 17'h01E);
    wait_done(8, nb);
    chk("busy_len8", 32'(nb), 32'(8));
    go(8, 16'h00, 16'h01, 0, 17'h1FF);
    wait_done(8, nb);
    go(8, 16'h80, 16'h7F, 1, 17'h000);
    wait_done(8, nb);

    // Start held high: three back-to-back operations
    @(negedge clk);
    repeat (3) q8.push_back(9'h1FF);
    s8 = 1; a8 = 8'hFF; b8 = 8'hFF; bi8 = 1;
    ndone = 0;
    tprev = 0;
    for (int t = 0; t < 60 && ndone < 3; t++) begin
      @(negedge clk);
      if (done8) begin
        if (ndone > 0) chk("b2b_gap", 32'(t - tprev), 32'(9));
        tprev = t;
        ndone++;
        if (ndone == 3) s8 = 0;
      end
    end
    chk("b2b_count", 32'(ndone), 32'(3));
    @(negedge clk);
    chk("b2b_width", 32'(done8), 32'(0));

    // Start during SHIFT is ignored
    go(8, 16'h10, 16'h01, 0, 17'h00F);
    @(negedge clk);
    s8 = 1; a8 = 8'hAA; b8 = 8'h00;
    @(negedge clk);
    s8 = 0;
    wait_done(8, nb);
    ndone = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("ignored", 32'(ndone), 32'(0));

    // Asynchronous reset mid-SHIFT
    @(negedge clk);
    s8 = 1; a8 = 8'h12; b8 = 8'h34; bi8 = 0;
    @(negedge clk);
    s8 = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 chk("arst", 32'({busy8, done8, bo8, d8}), 32'(0));
    @(negedge clk);
    rst = 0;
    ndone = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'(0));
    go(8, 16'h03, 16'h05, 0, 17'h1FE);
    wait_done(8, nb);

    // Random sweeps against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      go(1, ra, rb, rbi, model(1, ra, rb, rbi));
      wait_done(1, nb);
      chk("busy_len1", 32'(nb), 32'(1));
    end
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i == 0) ? ra : 16'($urandom);
      rbi = 1'($urandom);
      go(16, ra, rb, rbi, model(16, ra, rb, rbi));
      wait_done(16, nb);
      chk("busy_len16", 32'(nb), 32'(16));
    end

    repeat (3) @(negedge clk);
    chk("q8_empty", 32'(q8.size()), 32'(0));
    chk("q1_empty", 32'(q1.size()), 32'(0));
    chk("q16_empty", 32'(q16.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
